// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: a 2-entry skid buffer (head + skid) holding pre-formatted ALU results
// and store controls, with the head entry driving the memory stage and the forwarding path.
module ex_mem_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] read_b,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_addr,
    output logic [XLEN-1:0] out_wdata,
    output logic [3:0]      out_wstrb,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [2:0]      out_funct3,
    output logic            out_misaligned,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wstrb;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      funct3;
        logic            misaligned;
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t fmt;

    logic [1:0] a;
    logic       mis;
    logic       accept;
    logic       pop;

    // State encoding doubles as the occupancy count.
    assign in_ready  = ~reset & (32'(state_q) != DEPTH);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        a   = alu_result[1:0];
        mis = (mem_read | mem_write) &
              (((funct3[1:0] == 2'b01) & a[0]) | ((funct3[1:0] == 2'b10) & (a != 2'b00)));

        fmt            = '0;
        fmt.addr       = alu_result;
        fmt.wdata      = read_b;
        fmt.rd         = rd;
        fmt.reg_write  = reg_write & (rd != 5'd0);
        fmt.mem_read   = mem_read & ~mis;
        fmt.mem_write  = mem_write & ~mis;
        fmt.funct3     = funct3;
        fmt.misaligned = mis;

        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    fmt.wdata = {4{read_b[7:0]}};
                    fmt.wstrb = 4'b0001 << a;
                end
                2'b01: begin
                    fmt.wdata = {2{read_b[15:0]}};
                    fmt.wstrb = a[1] ? 4'b1100 : 4'b0011;
                end
                2'b10: fmt.wstrb = 4'b1111;
                default: ;
            endcase
        end
        if (mis) begin
            fmt.wstrb = 4'b0000;
        end
    end

    // Vacated slots are zeroed so the head drives reset values whenever it is empty.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = fmt;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = fmt;
                    end else if (accept) begin
                        skid_d  = fmt;
                        state_d = FULL;
                    end else if (pop) begin
                        head_d  = '0;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    head_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_addr       = head_q.addr;
    assign out_wdata      = head_q.wdata;
    assign out_wstrb      = head_q.wstrb;
    assign out_rd         = head_q.rd;
    assign out_reg_write  = head_q.reg_write;
    assign out_mem_read   = head_q.mem_read;
    assign out_mem_write  = head_q.mem_write;
    assign out_funct3     = head_q.funct3;
    assign out_misaligned = head_q.misaligned;
    assign fwd_valid      = out_valid & head_q.reg_write & ~head_q.mem_read & ~head_q.misaligned;
    assign fwd_rd         = head_q.rd;
    assign fwd_data       = head_q.addr;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: handshake, backpressure, store formatting, flush and reset.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] read_b;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic [3:0]  out_wstrb;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [2:0]  out_funct3;
    logic        out_misaligned;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .read_b        (read_b),
        .rd            (rd),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_wdata     (out_wdata),
        .out_wstrb     (out_wstrb),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_funct3    (out_funct3),
        .out_misaligned(out_misaligned),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] alu, input logic [31:0] b,
                       input logic [4:0] r, input logic rw, input logic mr, input logic mw,
                       input logic [2:0] f3);
        in_valid   = v;
        alu_result = alu;
        read_b     = b;
        rd         = r;
        reg_write  = rw;
        mem_read   = mr;
        mem_write  = mw;
        funct3     = f3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        #3;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_addr", out_addr, 32'h0);

        // Back-to-back ADDs with the memory stage always ready
        out_ready = 1'b1;
        drv(1'b1, 32'h5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        $display("b2b: addr=%h rd=%0d fwd_valid=%b", out_addr, fwd_rd, fwd_valid);
        chk("b2b0_valid", 32'(out_valid), 32'd1);
        chk("b2b0_addr", out_addr, 32'h5);
        chk("b2b0_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("b2b0_fwd_rd", 32'(fwd_rd), 32'd3);
        chk("b2b0_fwd_data", fwd_data, 32'h5);
        drv(1'b1, 32'h7, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        $display("b2b: addr=%h rd=%0d fwd_valid=%b", out_addr, fwd_rd, fwd_valid);
        chk("b2b1_addr", out_addr, 32'h7);
        chk("b2b1_fwd_rd", 32'(fwd_rd), 32'd4);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("b2b_drain_valid", 32'(out_valid), 32'd0);
        chk("b2b_drain_fwd", 32'(fwd_valid), 32'd0);
        chk("b2b_drain_addr", out_addr, 32'h0);

        // Backpressure: three offered, two accepted, then drained in order
        out_ready = 1'b0;
        drv(1'b1, 32'h11, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        chk("bp_one_ready", 32'(in_ready), 32'd1);
        drv(1'b1, 32'h22, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        drv(1'b1, 32'h33, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        $display("bp: hold addr=%h in_ready=%b", out_addr, in_ready);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_addr", out_addr, 32'h11);
        out_ready = 1'b1;
        tick();
        $display("bp: drain addr=%h", out_addr);
        chk("bp_drain_b", out_addr, 32'h22);
        chk("bp_drain_b_rd", 32'(out_rd), 32'd2);
        tick();
        $display("bp: drain addr=%h", out_addr);
        chk("bp_drain_c", out_addr, 32'h33);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Store formatting and misalignment
        drv(1'b1, 32'h1003, 32'hAABBCCDD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        $display("sb: wstrb=%b wdata=%h", out_wstrb, out_wdata);
        chk("sb_wstrb", 32'(out_wstrb), 32'h8);
        chk("sb_wdata", out_wdata, 32'hDDDDDDDD);
        chk("sb_mem_write", 32'(out_mem_write), 32'd1);
        drv(1'b1, 32'h1002, 32'hAABBCCDD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
        tick();
        $display("sh: wstrb=%b wdata=%h", out_wstrb, out_wdata);
        chk("sh_wstrb", 32'(out_wstrb), 32'hC);
        chk("sh_wdata", out_wdata, 32'hCCDDCCDD);
        chk("sh_misaligned", 32'(out_misaligned), 32'd0);
        drv(1'b1, 32'h1002, 32'hAABBCCDD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
        tick();
        $display("sw: misaligned=%b mem_write=%b wstrb=%b", out_misaligned, out_mem_write, out_wstrb);
        chk("sw_mis", 32'(out_misaligned), 32'd1);
        chk("sw_mem_write", 32'(out_mem_write), 32'd0);
        chk("sw_wstrb", 32'(out_wstrb), 32'h0);
        chk("sw_valid", 32'(out_valid), 32'd1);
        drv(1'b1, 32'h1001, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b001);
        tick();
        chk("lh_mis", 32'(out_misaligned), 32'd1);
        chk("lh_mem_read", 32'(out_mem_read), 32'd0);
        chk("lh_fwd", 32'(fwd_valid), 32'd0);
        drv(1'b1, 32'h1004, 32'h12345678, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010);
        tick();
        chk("lw_mem_read", 32'(out_mem_read), 32'd1);
        chk("lw_wstrb", 32'(out_wstrb), 32'h0);
        chk("lw_fwd", 32'(fwd_valid), 32'd0);
        chk("lw_reg_write", 32'(out_reg_write), 32'd1);
        drv(1'b1, 32'h99, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        chk("rd0_addr", out_addr, 32'h99);
        chk("rd0_reg_write", 32'(out_reg_write), 32'd0);
        chk("rd0_fwd", 32'(fwd_valid), 32'd0);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("st_empty", 32'(out_valid), 32'd0);

        // Flush in ONE with a simultaneous accept
        out_ready = 1'b0;
        drv(1'b1, 32'h44, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        chk("fl_one_addr", out_addr, 32'h44);
        drv(1'b1, 32'h55, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 3'b000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        $display("flush: out_valid=%b in_ready=%b addr=%h", out_valid, in_ready, out_addr);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_addr", out_addr, 32'h0);
        chk("fl_rd", 32'(out_rd), 32'd0);
        tick();
        chk("fl_stays_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        drv(1'b1, 32'h66, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        chk("fl_next_addr", out_addr, 32'h66);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("fl_next_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL and stalled
        out_ready = 1'b0;
        drv(1'b1, 32'hA0, 32'hFFFF0000, 5'd10, 1'b1, 1'b0, 1'b1, 3'b010);
        tick();
        drv(1'b1, 32'hB0, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("rst_pre_full", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        $display("reset: out_valid=%b addr=%h in_ready=%b", out_valid, out_addr, in_ready);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", out_addr, 32'h0);
        chk("rst_wdata", out_wdata, 32'h0);
        chk("rst_wstrb", 32'(out_wstrb), 32'h0);
        chk("rst_in_ready_hi", 32'(in_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready_rel", 32'(in_ready), 32'd1);
        tick();
        chk("rst_after_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
